// File: rtl/fir_sample_player.sv
// Stimulus source for the 8-tap moving-average filter: replays step, impulse or
// memory waveforms, sequences the filter reset and flushes it with zeros.
module fir_sample_player #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int DUT_RST_CYCLES = 2,
    parameter int STEP_CYCLES    = 20,
    parameter int DRAIN_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  sample_ready,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic [ADDR_WIDTH-1:0] sample_idx,
    output logic                  dut_reset_n,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int RST_W = ($clog2(DUT_RST_CYCLES + 1) < 1) ? 1 : $clog2(DUT_RST_CYCLES + 1);
    localparam int DRN_W = ($clog2(DRAIN_CYCLES + 1) < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] MODE_STEP    = 2'd0;
    localparam logic [1:0] MODE_IMPULSE = 2'd1;
    localparam logic [1:0] MODE_PLAY    = 2'd2;
    localparam logic [1:0] MODE_NULL    = 2'd3;

    localparam logic [DATA_WIDTH-1:0] FULL_SCALE = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUT_RST,
        ST_PLAY,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]      pay_cnt_q, pay_cnt_d;
    logic [DRN_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] length_q, length_d;
    logic [DATA_WIDTH-1:0] sample_out_q, sample_out_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [ADDR_WIDTH-1:0] sample_idx_q, sample_idx_d;
    logic                  dut_reset_n_q, dut_reset_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic                  mem_we;
    logic                  accept;
    logic [CNT_W-1:0]      last_cnt;
    logic [CNT_W-1:0]      rd_idx;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] payload_val;
    logic                  to_drain;
    logic                  to_done;

    assign mem_we = wr_en && (state_q == ST_IDLE) && !busy_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        accept   = sample_valid_q & sample_ready;
        last_cnt = (mode_q == MODE_PLAY) ? {1'b0, length_q} : CNT_W'(STEP_CYCLES - 1);
        rd_idx   = (state_q == ST_PLAY) ? pay_cnt_q + 1'b1 : '0;
        rd_addr  = rd_idx[ADDR_WIDTH-1:0];
        // Memory is read only into sample_out_q, giving a 1-cycle synchronous read.
        case (mode_q)
            MODE_PLAY:    payload_val = mem_q[rd_addr];
            MODE_IMPULSE: payload_val = (rd_idx == '0) ? FULL_SCALE : '0;
            default:      payload_val = FULL_SCALE;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        pay_cnt_d      = pay_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        mode_d         = mode_q;
        length_d       = length_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = sample_valid_q;
        sample_idx_d   = sample_idx_q;
        dut_reset_n_d  = dut_reset_n_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        to_drain       = 1'b0;
        to_done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dut_reset_n_d  = 1'b1;
                sample_valid_d = 1'b0;
                sample_out_d   = '0;
                sample_idx_d   = '0;
                busy_d         = 1'b0;
                if (start) begin
                    if (mode == MODE_NULL) begin
                        to_done = 1'b1;
                    end else begin
                        state_d       = ST_DUT_RST;
                        mode_d        = mode;
                        length_d      = length;
                        rst_cnt_d     = '0;
                        busy_d        = 1'b1;
                        dut_reset_n_d = 1'b0;
                    end
                end
            end
            ST_DUT_RST: begin
                if (rst_cnt_q == RST_W'(DUT_RST_CYCLES - 1)) begin
                    state_d        = ST_PLAY;
                    pay_cnt_d      = '0;
                    dut_reset_n_d  = 1'b1;
                    sample_valid_d = 1'b1;
                    sample_out_d   = payload_val;
                    sample_idx_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (accept) begin
                    if (pay_cnt_q == last_cnt) begin
                        to_drain = 1'b1;
                    end else begin
                        pay_cnt_d    = rd_idx;
                        sample_out_d = payload_val;
                        sample_idx_d = rd_addr;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    if (drain_cnt_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                        to_done = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d        = ST_IDLE;
                busy_d         = 1'b0;
                sample_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_drain) begin
            if (DRAIN_CYCLES == 0) begin
                to_done = 1'b1;
            end else begin
                state_d        = ST_DRAIN;
                drain_cnt_d    = '0;
                sample_out_d   = '0;
                sample_idx_d   = '0;
                sample_valid_d = 1'b1;
            end
        end

        if (to_done) begin
            state_d        = ST_DONE;
            done_d         = 1'b1;
            busy_d         = 1'b0;
            sample_valid_d = 1'b0;
            sample_out_d   = '0;
            sample_idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rst_cnt_q      <= '0;
            pay_cnt_q      <= '0;
            drain_cnt_q    <= '0;
            mode_q         <= '0;
            length_q       <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            dut_reset_n_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            pay_cnt_q      <= pay_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            mode_q         <= mode_d;
            length_q       <= length_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            dut_reset_n_q  <= dut_reset_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign dut_reset_n  = dut_reset_n_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fir_sample_player.sv
// Directed bench for fir_sample_player: step, impulse, memory playback,
// write gating, mid-run reset and null run.
module tb_fir_sample_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [1:0]  mode;
    logic [9:0]  length;
    logic        sample_ready;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [9:0]  sample_idx;
    logic        dut_reset_n;
    logic        busy;
    logic        done;

    fir_sample_player #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (10),
        .DUT_RST_CYCLES(2),
        .STEP_CYCLES   (20),
        .DRAIN_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .mode        (mode),
        .length      (length),
        .sample_ready(sample_ready),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .sample_idx  (sample_idx),
        .dut_reset_n (dut_reset_n),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [15:0] samp_q[$];
    logic [9:0]  idx_q[$];
    int rst_low, busy_cnt, unstable;
    bit got_done, aborted, done_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Observes from the first cycle after the start edge until done (or abort/budget).
    task automatic run(input bit toggle, input int abort_at, input int budget);
        bit          phase;
        bit          hold;
        logic [15:0] ho;
        logic [9:0]  hi;
        samp_q.delete();
        idx_q.delete();
        rst_low = 0; busy_cnt = 0; unstable = 0;
        got_done = 0; aborted = 0; phase = 1; hold = 0;
        ho = '0; hi = '0;
        for (int c = 0; c < budget; c++) begin
            if (hold && sample_valid && (sample_out !== ho || sample_idx !== hi)) unstable++;
            hold = 0;
            if (done) begin
                got_done = 1;
                break;
            end
            if (!dut_reset_n) rst_low++;
            if (busy) busy_cnt++;
            if (sample_valid) begin
                if (abort_at >= 0 && samp_q.size() == abort_at) begin
                    reset = 1;
                    aborted = 1;
                    break;
                end
                sample_ready = toggle ? phase : 1'b1;
                phase = !phase;
                if (sample_ready) begin
                    samp_q.push_back(sample_out);
                    idx_q.push_back(sample_idx);
                end else begin
                    hold = 1;
                    ho = sample_out;
                    hi = sample_idx;
                end
            end
            tick();
            wr_en = 0;
        end
    endtask

    // kind: 0 step, 1 impulse, 2 ramp mem[i]=i, 3 ramp with 0x8000 at index 0
    task automatic check_samples(input string tag, input int kind, input int n_pay, input int n_exp);
        int          mism;
        logic [15:0] e_out;
        logic [9:0]  e_idx;
        mism = 0;
        for (int i = 0; i < samp_q.size(); i++) begin
            if (i < n_pay) begin
                case (kind)
                    0:       e_out = 16'h7fff;
                    1:       e_out = (i == 0) ? 16'h7fff : 16'h0000;
                    2:       e_out = 16'(i);
                    default: e_out = (i == 0) ? 16'h8000 : 16'(i);
                endcase
                e_idx = 10'(i);
            end else begin
                e_out = '0;
                e_idx = '0;
            end
            if (samp_q[i] !== e_out || idx_q[i] !== e_idx) mism++;
        end
        chk({tag, "_count"}, samp_q.size(), n_exp);
        chk({tag, "_data_mismatches"}, mism, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
        start = 0; mode = '0; length = '0; sample_ready = 0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_flags", {sample_valid, busy, dut_reset_n, done}, 4'b0000);
            chk("rst_out", sample_out, 16'h0);
            chk("rst_idx", sample_idx, 10'h0);
        end
        reset = 0;
        tick();
        chk("rel_dut_reset_n", dut_reset_n, 1);
        chk("rel_busy", busy, 0);
        chk("rel_valid", sample_valid, 0);

        // Step, ready always high
        mode = 2'd0; start = 1; sample_ready = 1;
        tick();
        start = 0;
        chk("step_busy_next", busy, 1);
        chk("step_dut_rst", dut_reset_n, 0);
        run(0, -1, 200);
        chk("step_done", got_done, 1);
        chk("step_rst_low", rst_low, 2);
        chk("step_busy_cycles", busy_cnt, 30);
        chk("step_done_busy", busy, 0);
        chk("step_done_valid", sample_valid, 0);
        check_samples("step", 0, 20, 28);
        start = 1;
        tick();
        start = 0;
        chk("done_start_ign_done", done, 0);
        chk("done_start_ign_busy", busy, 0);
        chk("done_start_ign_rstn", dut_reset_n, 1);
        tick();
        chk("done_start_ign_busy2", busy, 0);

        // Impulse, ready toggling 1,0,1,0
        mode = 2'd1; start = 1;
        tick();
        start = 0;
        run(1, -1, 300);
        chk("imp_done", got_done, 1);
        chk("imp_rst_low", rst_low, 2);
        chk("imp_busy_cycles", busy_cnt, 57);
        chk("imp_unstable", unstable, 0);
        check_samples("imp", 1, 20, 28);
        sample_ready = 1;
        tick();
        chk("imp_done_pulse", done, 0);

        // Full-depth playback of mem[i]=i
        for (int i = 0; i < 1024; i++) begin
            wr_en = 1; wr_addr = 10'(i); wr_data = 16'(i);
            tick();
        end
        wr_en = 0;
        mode = 2'd2; length = 10'd1023; start = 1;
        tick();
        start = 0;
        run(0, -1, 1200);
        chk("play_done", got_done, 1);
        chk("play_busy_cycles", busy_cnt, 1034);
        check_samples("play", 2, 1024, 1032);
        tick();

        // Write while busy is dropped
        mode = 2'd2; length = 10'd7; start = 1;
        tick();
        start = 0;
        wr_en = 1; wr_addr = 10'd5; wr_data = 16'h1234;
        run(0, -1, 100);
        chk("wbusy_done", got_done, 1);
        check_samples("wbusy", 2, 8, 16);
        chk("wbusy_mem5", samp_q.size() > 5 ? 32'(samp_q[5]) : 32'hdead, 16'h0005);
        tick();

        // Write and start in the same IDLE cycle
        wr_en = 1; wr_addr = 10'd0; wr_data = 16'h8000;
        mode = 2'd2; length = 10'd7; start = 1;
        tick();
        start = 0; wr_en = 0;
        run(0, -1, 100);
        chk("wstart_done", got_done, 1);
        check_samples("wstart", 3, 8, 16);
        tick();

        // Reset at playback sample 300
        mode = 2'd2; length = 10'd1023; start = 1;
        tick();
        start = 0;
        run(0, 300, 1000);
        chk("abort_hit", aborted, 1);
        check_samples("abort", 3, 1024, 300);
        tick();
        chk("abort_valid", sample_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rstn", dut_reset_n, 0);
        chk("abort_done", done, 0);
        reset = 0;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            done_seen |= done;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_idle_rstn", dut_reset_n, 1);

        // Null run
        mode = 2'd3; start = 1;
        tick();
        start = 0;
        chk("null_done", done, 1);
        chk("null_valid", sample_valid, 0);
        chk("null_busy", busy, 0);
        chk("null_rstn", dut_reset_n, 1);
        tick();
        chk("null_done_clr", done, 0);
        chk("null_valid2", sample_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
